// File: rtl/bit_serial_adder_if.sv
// Operand/result bus of the bit-serial adder plus the link to the external 1-bit full adder.
// slave is the controller's view; master is the view of the software/test side and the full adder.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             Cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S_out;
    logic             Cout_out;
    logic             fa_A;
    logic             fa_B;
    logic             fa_Cin;
    logic             fa_S;
    logic             fa_Cout;

    modport slave (
        input  start, A_in, B_in, Cin_in, fa_S, fa_Cout,
        output busy, done, S_out, Cout_out, fa_A, fa_B, fa_Cin
    );

    modport master (
        output start, A_in, B_in, Cin_in, fa_S, fa_Cout,
        input  busy, done, S_out, Cout_out, fa_A, fa_B, fa_Cin
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Streams two WIDTH-bit operands LSB-first through an external full adder and collects
// the sum bit by bit, feeding the registered carry back each cycle.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    bit_serial_adder_if.slave   bus
);
    // state   | meaning
    // IDLE    | waiting for start, full adder inputs held at 0
    // RUN     | one operand bit per cycle through the full adder, WIDTH cycles
    // DONE    | result registered, done pulses for one cycle
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             run;
    logic             last_bit;

    assign run      = (state == ST_RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Full adder inputs are gated so the adder sees zeros outside RUN.
    assign bus.fa_A     = run & a_sh[0];
    assign bus.fa_B     = run & b_sh[0];
    assign bus.fa_Cin   = run & carry;
    assign bus.busy     = (state == ST_RUN) || (state == ST_DONE);
    assign bus.done     = (state == ST_DONE);
    assign bus.S_out    = s_reg;
    assign bus.Cout_out = cout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A_in;
                        b_sh  <= bus.B_in;
                        carry <= bus.Cin_in;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_sh  <= {bus.fa_S, s_sh[WIDTH-1:1]};
                    carry <= bus.fa_Cout;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    // Final sum bit goes straight into the result so it is valid in DONE.
                    if (last_bit) begin
                        s_reg    <= {bus.fa_S, s_sh[WIDTH-1:1]};
                        cout_reg <= bus.fa_Cout;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: stimulus pushes A+B+Cin results, a negedge monitor
// pops them on each done pulse and also watches output stability and idle full-adder inputs.
module tb_bit_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W:0] val;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   dones;
    int   ops;
    exp_t exp_q[$];
    logic [W-1:0] last_s;
    logic         last_c;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural full adder
    assign bus.fa_S    = bus.fa_A ^ bus.fa_B ^ bus.fa_Cin;
    assign bus.fa_Cout = (bus.fa_A & bus.fa_B) | (bus.fa_A & bus.fa_Cin) | (bus.fa_B & bus.fa_Cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_s = '0;
            last_c = 1'b0;
        end else begin
            if (bus.done) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got S=%h C=%b with empty scoreboard", bus.S_out, bus.Cout_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.Cout_out, bus.S_out} !== e.val) begin
                        errors++;
                        $display("FAIL result got %h expected %h", {bus.Cout_out, bus.S_out}, e.val);
                    end
                    checks++;
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL done_latency got cycle %0d expected %0d", cyc, e.cyc);
                    end
                end
                last_s = bus.S_out;
                last_c = bus.Cout_out;
            end else begin
                checks++;
                if (bus.S_out !== last_s || bus.Cout_out !== last_c) begin
                    errors++;
                    $display("FAIL result_stable got %h/%b expected %h/%b", bus.S_out, bus.Cout_out, last_s, last_c);
                end
            end
            if (!bus.busy || bus.done) begin
                checks++;
                if ({bus.fa_A, bus.fa_B, bus.fa_Cin} !== 3'b000) begin
                    errors++;
                    $display("FAIL fa_idle got %b expected 000", {bus.fa_A, bus.fa_B, bus.fa_Cin});
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b expected 0", bus.busy);
        end
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // Carry into bit i of a+b+c, from plain arithmetic on the low i bits
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int i);
        longint mask;
        longint s;
        mask = (longint'(1) << i) - 1;
        s = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        return s[i];
    endfunction

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        e.val = model_sum(a, b, c);
        e.cyc = cyc + W;
        exp_q.push_back(e);
        ops++;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit trace);
        wait_idle();
        bus.A_in   = a;
        bus.B_in   = b;
        bus.Cin_in = c;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_exp(a, b, c);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        if (trace) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check($sformatf("fa_A[%0d]", i), 32'(bus.fa_A), 32'(a[i]));
                check($sformatf("fa_Cin[%0d]", i), 32'(bus.fa_Cin), 32'(carry_into(a, b, c, i)));
            end
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        int acc[3];
        int d0;
        cyc = 0; checks = 0; errors = 0; dones = 0; ops = 0;
        last_s = '0; last_c = 1'b0;
        bus.start = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.Cin_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_S_out", 32'(bus.S_out), 32'd0);
        check("rst_Cout_out", 32'(bus.Cout_out), 32'd0);
        check("rst_fa", 32'({bus.fa_A, bus.fa_B, bus.fa_Cin}), 32'd0);
        rst = 1'b0;

        issue(8'h3C, 8'h42, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'hA5, 8'h5A, 1'b1, 1'b0);
        issue(8'h03, 8'h01, 1'b0, 1'b1);
        wait_drain();
        check("tp3_S_out", 32'(bus.S_out), 32'h04);

        // Start pulses during RUN and DONE must be ignored
        d0 = dones;
        issue(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.A_in = 8'hFF; bus.B_in = 8'hFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("tp4_one_done", 32'(dones - d0), 32'd1);
        check("tp4_S_out", 32'(bus.S_out), 32'h30);
        check("tp4_busy_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-run
        issue(8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_fa_A", 32'(bus.fa_A), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        ops--;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_S_out", 32'(bus.S_out), 32'd0);
        check("arst_Cout_out", 32'(bus.Cout_out), 32'd0);
        check("arst_fa", 32'({bus.fa_A, bus.fa_B, bus.fa_Cin}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        wait_drain();
        check("tp5_S_out", 32'(bus.S_out), 32'h02);

        // Start held high: back-to-back operations
        wait_idle();
        bus.A_in = 8'h80; bus.B_in = 8'h80; bus.Cin_in = 1'b0; bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_idle();
            @(posedge clk);
            #1;
            push_exp(8'h80, 8'h80, 1'b0);
            acc[k] = cyc;
        end
        bus.start = 1'b0;
        wait_drain();
        check("tp6_spacing_1", 32'(acc[1] - acc[0]), 32'(W + 2));
        check("tp6_spacing_2", 32'(acc[2] - acc[1]), 32'(W + 2));

        // Randomized operations, some with full per-bit tracing
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, (n % 4) == 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.A_in = W'($urandom); bus.B_in = W'($urandom); bus.Cin_in = ~rc;
            end
        end
        wait_drain();
        repeat (4) @(negedge clk);
        check("pending_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'(ops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
